// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between NUM_REQ
// requesters. A round-robin pick in IDLE latches the winner's op and operands.
// EXEC drives the ALU for one cycle and registers its result. RESP holds that
// result on a one-hot valid/ready channel until the owner takes it.
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [3*NUM_REQ-1:0]    req_op,
   input  logic [XLEN*NUM_REQ-1:0] req_a,
   input  logic [XLEN*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [XLEN-1:0]         rsp_result,
   output logic                    rsp_zero,
   output logic                    rsp_err,
   output logic [2:0]              alu_control,
   output logic [XLEN-1:0]         alu_a,
   output logic [XLEN-1:0]         alu_b,
   input  logic [XLEN-1:0]         alu_result,
   input  logic                    alu_zero
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [IW-1:0]        rr_ptr_r;
   logic [IW-1:0]        owner_r;
   logic [IW-1:0]        grant_idx_s;
   logic                 grant_found_s;
   logic                 accept_s;
   logic                 rsp_done_s;
   logic [NUM_REQ-1:0]   grant_onehot_s;
   logic [NUM_REQ-1:0]   owner_onehot_s;

   // Round-robin search: first valid requester after the last winner.
   always_comb begin
      int scan_idx;
      scan_idx      = 0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_r) + k) % NUM_REQ;
         if (!grant_found_s && req_valid[scan_idx]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = IW'(scan_idx);
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // One-hot decode of grant and owner; ready only in IDLE and never during reset.
   always_comb begin
      grant_onehot_s              = '0;
      owner_onehot_s              = '0;
      grant_onehot_s[grant_idx_s] = 1'b1;
      owner_onehot_s[owner_r]     = 1'b1;
      accept_s   = (state_r == IDLE) && grant_found_s && !rst;
      rsp_done_s = (state_r == RESP) && rsp_ready[owner_r];
      if (accept_s) begin
         req_ready = grant_onehot_s;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state logic for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (rsp_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture the winner; these registers drive the ALU directly and hold afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r    <= IW'(NUM_REQ - 1);
         owner_r     <= '0;
         alu_control <= 3'd0;
         alu_a       <= '0;
         alu_b       <= '0;
      end else if (accept_s) begin
         rr_ptr_r    <= grant_idx_s;
         owner_r     <= grant_idx_s;
         alu_control <= req_op[3*int'(grant_idx_s) +: 3];
         alu_a       <= req_a[XLEN*int'(grant_idx_s) +: XLEN];
         alu_b       <= req_b[XLEN*int'(grant_idx_s) +: XLEN];
      end else begin
         rr_ptr_r    <= rr_ptr_r;
         owner_r     <= owner_r;
         alu_control <= alu_control;
         alu_a       <= alu_a;
         alu_b       <= alu_b;
      end
   end

   // Response registers: load at the end of EXEC, hold until the owner's handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (state_r == EXEC) begin
         rsp_valid  <= owner_onehot_s;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         rsp_err    <= (alu_control > 3'd4);
      end else if (rsp_done_s) begin
         rsp_valid  <= '0;
         rsp_result <= rsp_result;
         rsp_zero   <= rsp_zero;
         rsp_err    <= rsp_err;
      end else begin
         rsp_valid  <= rsp_valid;
         rsp_result <= rsp_result;
         rsp_zero   <= rsp_zero;
         rsp_err    <= rsp_err;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. A stub ALU answers on the alu_* ports, and a
// transaction-level model predicts the requester-side outputs every cycle.
// Directed tests also pin literal results.
module tb_alu_share_arbiter;

   localparam int NR = 2;
   localparam int XL = 32;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [3*NR-1:0]   req_op;
   logic [XL*NR-1:0]  req_a;
   logic [XL*NR-1:0]  req_b;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [XL-1:0]     rsp_result;
   logic              rsp_zero;
   logic              rsp_err;
   logic [2:0]        alu_control;
   logic [XL-1:0]     alu_a;
   logic [XL-1:0]     alu_b;
   logic [XL-1:0]     alu_result;
   logic              alu_zero;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XL-1:0] alu_fn(input logic [2:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Stub ALU outside the DUT.
   always_comb begin
      alu_result = alu_fn(alu_control, alu_a, alu_b);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // m_phase: 0 waiting for a grant, 1 operation in the ALU, 2 result offered
   int            m_phase;
   int            m_last;
   int            m_owner;
   int            m_win;
   logic [2:0]    m_op;
   logic [XL-1:0] m_a, m_b, m_res;

   function automatic int winner(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   always_comb m_win = winner(m_last, req_valid);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_last  <= NR - 1;
      end else if (m_phase == 0) begin
         if (m_win >= 0) begin
            m_owner <= m_win;
            m_last  <= m_win;
            m_op    <= req_op[3*m_win +: 3];
            m_a     <= req_a[XL*m_win +: XL];
            m_b     <= req_b[XL*m_win +: XL];
            m_res   <= alu_fn(req_op[3*m_win +: 3], req_a[XL*m_win +: XL], req_b[XL*m_win +: XL]);
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         m_phase <= 2;
      end else begin
         if (rsp_ready[m_owner]) m_phase <= 0;
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      logic [NR-1:0] exp_ready;
      logic [NR-1:0] exp_valid;
      exp_ready = '0;
      exp_valid = '0;
      if (m_phase == 0 && !rst && m_win >= 0) exp_ready[m_win] = 1'b1;
      if (m_phase == 2) exp_valid[m_owner] = 1'b1;
      chk("mdl_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("mdl_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (m_phase == 1) begin
         chk("mdl_alu_control", 32'(alu_control), 32'(m_op));
         chk("mdl_alu_a", alu_a, m_a);
         chk("mdl_alu_b", alu_b, m_b);
      end
      if (m_phase == 2) begin
         chk("mdl_rsp_result", rsp_result, m_res);
         chk("mdl_rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
         chk("mdl_rsp_err", 32'(rsp_err), 32'(m_op > 3'd4));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_req(input int idx, input logic [2:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
      req_op[3*idx +: 3] = op;
      req_a[XL*idx +: XL] = a;
      req_b[XL*idx +: XL] = b;
   endtask

   task automatic wait_ready(input int idx);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[idx]) break;
      end
      chk("grant_wait", 32'(req_ready[idx]), 32'd1);
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid != '0) break;
      end
      chk("rsp_wait", 32'(rsp_valid != '0), 32'd1);
   endtask

   task automatic do_req(input int idx, input logic [2:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b,
                         input logic [XL-1:0] res, input logic z, input logic e, input string nm);
      logic [NR-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      @(posedge clk); #1;
      set_req(idx, op, a, b);
      req_valid[idx] = 1'b1;
      wait_ready(idx);
      chk({nm, "_grant"}, 32'(req_ready), 32'(oh));
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
      @(negedge clk);
      chk({nm, "_exec_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_exec_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({nm, "_valid"}, 32'(rsp_valid), 32'(oh));
      chk({nm, "_result"}, rsp_result, res);
      chk({nm, "_zero"}, 32'(rsp_zero), 32'(z));
      chk({nm, "_err"}, 32'(rsp_err), 32'(e));
   endtask

   initial begin
      logic [NR-1:0] exp_oh;
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu_control", 32'(alu_control), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      rst = 1'b0;

      // single ADD, SUB giving zero on requester 1
      do_req(0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add");
      do_req(1, 3'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, "sub_zero");

      // round robin with both requesters held valid
      @(posedge clk); #1;
      set_req(0, 3'd0, 32'd1, 32'd1);
      set_req(1, 3'd3, 32'h0000_00F0, 32'h0000_000F);
      req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_rsp();
         exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
         chk("rr_owner", 32'(rsp_valid), 32'(exp_oh));
         chk("rr_result", rsp_result, (n % 2 == 0) ? 32'd2 : 32'h0000_00FF);
      end
      @(posedge clk); #1;
      req_valid = '0;

      // back-pressure on requester 0 while requester 1 waits
      @(posedge clk); #1;
      rsp_ready = 2'b10;
      set_req(0, 3'd0, 32'd100, 32'd23);
      req_valid = 2'b01;
      wait_ready(0);
      @(posedge clk); #1;
      set_req(1, 3'd2, 32'h0000_FF00, 32'h0000_0FF0);
      req_valid = 2'b10;
      wait_rsp();
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_result", rsp_result, 32'd123);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("bp_release_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
      chk("bp_idle_grant", 32'(req_ready), 32'd2);
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp();
      chk("bp_next_owner", 32'(rsp_valid), 32'd2);
      chk("bp_next_result", rsp_result, 32'h0000_0F00);

      // illegal op
      do_req(0, 3'd7, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "illegal");

      // reset while the operation is in EXEC
      @(posedge clk); #1;
      set_req(0, 3'd1, 32'd9, 32'd4);
      set_req(1, 3'd0, 32'd0, 32'd0);
      req_valid = 2'b01;
      wait_ready(0);
      @(posedge clk); #1;
      req_valid = 2'b11;
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 3'd0, 32'd1, 32'd1);
      @(negedge clk);
      chk("post_rst_grant", 32'(req_ready), 32'd1);
      chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("post_rst_exec_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_valid", 32'(rsp_valid), 32'd1);
      chk("post_rst_result", rsp_result, 32'd2);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
